// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
// uart_pkg
// Shared definitions for the buffered UART transmitter:
//   - tx_state_t        : one-hot TX FSM state encoding (IDLE, START, DATA, STOP)
//   - DATA_BITS         : data bits per frame (8N1)
//   - STOP_BITS         : stop bits per frame
//   - calc_clks_per_bit : clocks per bit from clock frequency and line rate
package uart_pkg;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_START = 4'b0010,
        ST_DATA  = 4'b0100,
        ST_STOP  = 4'b1000
    } tx_state_t;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    // Integer division: any fractional remainder is absorbed as a small baud error.
    function automatic int calc_clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
`timescale 1ns/1ps
// uart_fifo
// Synchronous single-clock FIFO holding bytes waiting for the serialiser.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset (pointers/count only)
//   push       : write request; ignored while full
//   push_data  : byte written on an accepted push
//   pop        : read request; ignored while empty
//   head       : byte at the read pointer (valid when not empty)
//   count      : number of stored bytes, 0..DEPTH
//   full/empty : decoded from the registered count
module uart_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    // The full check uses the registered count, so a pop in the same cycle
    // never makes room for a write that arrives while full.
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // Pointers are AW bits wide, so they wrap modulo DEPTH (a power of 2).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries data only and needs no reset.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_tx_buffered.sv
`timescale 1ns/1ps
// uart_tx_buffered
// Serial back end of the voltage-reporting path: queues ASCII characters from
// the formatting controller and sends them as 8N1 UART frames.
// Ports:
//   clk, rst  : system clock, asynchronous active-high reset
//   wr_en     : one-cycle write strobe (producer's tick)
//   wr_data   : byte to queue (producer's sign)
//   tx        : registered UART line, idles high
//   busy      : frame on the line or bytes still queued (registered)
//   full      : FIFO holds FIFO_DEPTH bytes
//   empty     : FIFO holds no bytes
//   overflow  : sticky, set when a write is dropped; cleared only by rst
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 65_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       tx,
    output logic       busy,
    output logic       full,
    output logic       empty,
    output logic       overflow
);

    localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD);
    localparam int STOP_CLKS    = CLKS_PER_BIT * STOP_BITS;
    localparam int BAUD_W       = $clog2(STOP_CLKS + 1);
    localparam int BIT_W        = $clog2(DATA_BITS);
    localparam int CNT_W        = $clog2(FIFO_DEPTH) + 1;

    localparam logic [BAUD_W-1:0] BIT_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] STOP_LAST = BAUD_W'(STOP_CLKS - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_BITS - 1);

    tx_state_t            state;
    logic [BAUD_W-1:0]    baud_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic [DATA_BITS-1:0] fifo_head;
    logic [CNT_W-1:0]     fifo_count;
    logic [CNT_W-1:0]     count_nxt;
    logic                 push_ok;
    logic                 pop;
    logic                 at_pop_point;
    logic                 bit_end;
    logic                 stop_end;
    logic                 busy_nxt;

    uart_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (wr_en),
        .push_data (wr_data),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (full),
        .empty     (empty)
    );

    assign push_ok  = wr_en & ~full;
    assign bit_end  = (baud_cnt == BIT_LAST);
    assign stop_end = (baud_cnt == STOP_LAST);

    // A new frame can start from IDLE or on the last cycle of a stop bit;
    // popping at the stop boundary keeps frames back-to-back with no idle bit.
    assign at_pop_point = (state == ST_IDLE) | ((state == ST_STOP) & stop_end);
    assign pop          = at_pop_point & ~empty;

    // busy is registered but must match the state/FIFO contents after this
    // edge, so it is built from the next-cycle view of both.
    assign count_nxt = fifo_count + CNT_W'(push_ok) - CNT_W'(pop);
    assign busy_nxt  = ~(at_pop_point & empty) | (count_nxt != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            tx       <= 1'b1;
            busy     <= 1'b0;
            overflow <= 1'b0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
        end else begin
            busy     <= busy_nxt;
            overflow <= overflow | (wr_en & full);
            case (state)
                ST_IDLE: begin
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    if (!empty) begin
                        state <= ST_START;
                        tx    <= 1'b0;
                    end else begin
                        tx    <= 1'b1;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        state    <= ST_DATA;
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        tx       <= shift[0];
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_cnt == LAST_BIT) begin
                            state <= ST_STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            tx      <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (stop_end) begin
                        baud_cnt <= '0;
                        if (!empty) begin
                            state <= ST_START;
                            tx    <= 1'b0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    tx       <= 1'b1;
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                end
            endcase
        end
    end

    // Shift register: loaded on pop, shifted right as each data bit completes.
    always_ff @(posedge clk) begin
        if (pop)
            shift <= fifo_head;
        else if ((state == ST_DATA) && bit_end)
            shift <= shift >> 1;
    end

endmodule
